warp_fetch_queue: RTL and testbench

WARP_FETCH_QUEUE -- requirements
Module: warp_fetch_queue

---
 rtl/warp_fetch_queue.sv | 84 ++++++++
 tb/tb_warp_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/warp_fetch_queue.sv
// Fetch-to-decode bundle queue: FWFT FIFO, head visible on o_deq_* the cycle it is valid (0 latency).
// Backpressure: o_enq_ready drops when full regardless of same-cycle dequeue; empty-mask bundles are accepted and dropped.
module warp_fetch_queue #(
  parameter int LANES  = 2,
  parameter int INST_W = 32,
  parameter int PC_W   = 64,
  parameter int DEPTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_enq_valid,
  output logic                    o_enq_ready,
  input  logic [LANES*INST_W-1:0] i_enq_inst,
  input  logic [LANES-1:0]        i_enq_mask,
  input  logic [PC_W-1:0]         i_enq_pc,
  output logic                    o_deq_valid,
  input  logic                    i_deq_ready,
  output logic [LANES*INST_W-1:0] o_deq_inst,
  output logic [LANES-1:0]        o_deq_mask,
  output logic [PC_W-1:0]         o_deq_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [LANES*INST_W-1:0] inst;
    logic [LANES-1:0]        mask;
    logic [PC_W-1:0]         pc;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;

  assign o_enq_ready = (count < CNT_W'(DEPTH));
  assign o_deq_valid = (count != '0);
  assign o_count     = count;

  // A handshake with no valid slots completes but never occupies an entry.
  assign push = i_enq_valid & o_enq_ready & (|i_enq_mask);
  assign pop  = o_deq_valid & i_deq_ready;

  assign head       = mem[rd_ptr];
  assign o_deq_inst = o_deq_valid ? head.inst : '0;
  assign o_deq_mask = o_deq_valid ? head.mask : '0;
  assign o_deq_pc   = o_deq_valid ? head.pc   : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{inst: i_enq_inst, mask: i_enq_mask, pc: i_enq_pc};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // Pointers wrap naturally since DEPTH is a power of two; count separates full from empty.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_fetch_queue.sv
// Scoreboard bench for warp_fetch_queue at default parameters.
module tb_warp_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] inst;
    logic [1:0]  mask;
    logic [63:0] pc;
  } ent_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_enq_valid;
  logic        o_enq_ready;
  logic [63:0] i_enq_inst;
  logic [1:0]  i_enq_mask;
  logic [63:0] i_enq_pc;
  logic        o_deq_valid;
  logic        i_deq_ready;
  logic [63:0] o_deq_inst;
  logic [1:0]  o_deq_mask;
  logic [63:0] o_deq_pc;
  logic [2:0]  o_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t exp_q[$];

  warp_fetch_queue dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_enq_valid (i_enq_valid),
    .o_enq_ready (o_enq_ready),
    .i_enq_inst  (i_enq_inst),
    .i_enq_mask  (i_enq_mask),
    .i_enq_pc    (i_enq_pc),
    .o_deq_valid (o_deq_valid),
    .i_deq_ready (i_deq_ready),
    .o_deq_inst  (o_deq_inst),
    .o_deq_mask  (o_deq_mask),
    .o_deq_pc    (o_deq_pc),
    .o_count     (o_count)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] mk_inst(input logic [63:0] pc);
    return {~pc[31:0], pc[31:0] ^ 32'h1234_5678};
  endfunction

  task automatic drive(input logic ev, input logic [1:0] m, input logic [63:0] pc,
                       input logic dr, input logic fl);
    i_enq_valid = ev;
    i_enq_mask  = m;
    i_enq_pc    = pc;
    i_enq_inst  = mk_inst(pc);
    i_deq_ready = dr;
    i_flush     = fl;
    #1;
  endtask

  // Advance one clock and update the reference queue from the bench's own view of the handshake.
  task automatic tick();
    logic acc;
    logic deq;
    ent_t e;
    acc = i_enq_valid && (exp_q.size() < DEPTH) && (i_enq_mask != 2'b00);
    deq = i_deq_ready && (exp_q.size() > 0);
    e   = '{inst: i_enq_inst, mask: i_enq_mask, pc: i_enq_pc};
    @(posedge i_clk);
    #1;
    if (i_flush) exp_q.delete();
    else begin
      if (deq) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    drive(1'b1, 2'b11, 64'hDEAD, 1'b1, 1'b0);
    repeat (2) tick();
    exp_q.delete();
    n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", o_count); end
    n_cmp++; if (o_deq_valid !== 1'b0) begin n_bad++; $display("FAIL rst_deq_valid got %b want 0", o_deq_valid); end
    n_cmp++; if (o_enq_ready !== 1'b1) begin n_bad++; $display("FAIL rst_enq_ready got %b want 1", o_enq_ready); end
    n_cmp++; if ({o_deq_inst, o_deq_mask, o_deq_pc} !== '0) begin n_bad++; $display("FAIL rst_data got %h/%b/%h want 0", o_deq_inst, o_deq_mask, o_deq_pc); end
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic drain_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 2'b00, 64'h0, 1'b1, 1'b0);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++; $display("FAIL %s_model_empty at %0d", tag, k);
      end else begin
        n_cmp++; if (o_deq_valid !== 1'b1 || o_deq_pc !== exp_q[0].pc || o_deq_inst !== exp_q[0].inst || o_deq_mask !== exp_q[0].mask) begin
          n_bad++; $display("FAIL %s_head%0d got v=%b pc=%h inst=%h m=%b want pc=%h inst=%h m=%b",
                            tag, k, o_deq_valid, o_deq_pc, o_deq_inst, o_deq_mask, exp_q[0].pc, exp_q[0].inst, exp_q[0].mask);
        end
      end
      tick();
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b11, 64'h100 + 64'(8*k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (o_count !== 3'd4) begin n_bad++; $display("FAIL fill_count got %0d want 4", o_count); end
    n_cmp++; if (o_enq_ready !== 1'b0) begin n_bad++; $display("FAIL fill_enq_ready got %b want 0", o_enq_ready); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b00, 64'h0, 1'b1, 1'b0);
      n_cmp++; if (o_deq_pc !== 64'h100 + 64'(8*k)) begin n_bad++; $display("FAIL drain_pc%0d got %h want %h", k, o_deq_pc, 64'h100 + 64'(8*k)); end
      n_cmp++; if (o_deq_inst !== mk_inst(64'h100 + 64'(8*k)) || o_deq_mask !== 2'b11) begin n_bad++; $display("FAIL drain_data%0d got %h/%b", k, o_deq_inst, o_deq_mask); end
      tick();
    end
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (o_count !== 3'd0 || o_deq_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty got cnt=%0d v=%b want 0/0", o_count, o_deq_valid); end
    n_cmp++; if ({o_deq_inst, o_deq_mask, o_deq_pc} !== '0) begin n_bad++; $display("FAIL drain_zero got %h/%b/%h want 0", o_deq_inst, o_deq_mask, o_deq_pc); end
  endtask

  task automatic test_full_concurrent();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b10, 64'h500 + 64'(8*k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 2'b01, 64'h520, 1'b1, 1'b0);
    n_cmp++; if (o_enq_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", o_enq_ready); end
    tick();
    n_cmp++; if (o_count !== 3'd3) begin n_bad++; $display("FAIL full_deq_count got %0d want 3", o_count); end
    drive(1'b1, 2'b01, 64'h520, 1'b0, 1'b0);
    tick();
    n_cmp++; if (o_count !== 3'd4) begin n_bad++; $display("FAIL full_reenq_count got %0d want 4", o_count); end
    n_cmp++; if (o_deq_pc !== 64'h508) begin n_bad++; $display("FAIL full_head got %h want 508", o_deq_pc); end
    drain_check("full", 4);
  endtask

  task automatic test_wrap();
    drive(1'b1, 2'b11, 64'h600, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 2'b11, 64'h608 + 64'(8*k), 1'b1, 1'b0);
      n_cmp++; if (o_deq_pc !== 64'h600 + 64'(8*k) || o_deq_inst !== exp_q[0].inst) begin
        n_bad++; $display("FAIL wrap_head%0d got %h want %h", k, o_deq_pc, 64'h600 + 64'(8*k));
      end
      tick();
      n_cmp++; if (o_count !== 3'd1) begin n_bad++; $display("FAIL wrap_count%0d got %0d want 1", k, o_count); end
    end
    drain_check("wrap", 1);
  endtask

  task automatic test_empty_mask();
    drive(1'b1, 2'b00, 64'h200, 1'b0, 1'b0);
    n_cmp++; if (o_enq_ready !== 1'b1) begin n_bad++; $display("FAIL emask_ready got %b want 1", o_enq_ready); end
    tick();
    n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL emask_count got %0d want 0", o_count); end
    drive(1'b1, 2'b01, 64'h204, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (o_count !== 3'd1 || o_deq_pc !== 64'h204 || o_deq_mask !== 2'b01) begin
      n_bad++; $display("FAIL emask_head got cnt=%0d pc=%h m=%b want 1/204/01", o_count, o_deq_pc, o_deq_mask);
    end
    drain_check("emask", 1);
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b11, 64'h2F0 + 64'(4*k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 2'b11, 64'h300, 1'b1, 1'b1);
    tick();
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (o_count !== 3'd0 || o_deq_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty got cnt=%0d v=%b want 0/0", o_count, o_deq_valid); end
    drive(1'b1, 2'b11, 64'h308, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (o_deq_pc !== 64'h308 || o_count !== 3'd1) begin n_bad++; $display("FAIL flush_next got pc=%h cnt=%0d want 308/1", o_deq_pc, o_count); end
    drain_check("flush", 1);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 2'b11, 64'h3F0 + 64'(8*k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    #1;
    i_rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_cmp++; if (o_count !== 3'd0 || o_deq_valid !== 1'b0) begin n_bad++; $display("FAIL arst_now got cnt=%0d v=%b want 0/0", o_count, o_deq_valid); end
    n_cmp++; if (o_deq_pc !== 64'h0 || o_enq_ready !== 1'b1) begin n_bad++; $display("FAIL arst_out got pc=%h rdy=%b want 0/1", o_deq_pc, o_enq_ready); end
    #1;
    i_rst_n = 1'b1;
    drive(1'b1, 2'b11, 64'h400, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (o_deq_pc !== 64'h400 || o_count !== 3'd1) begin n_bad++; $display("FAIL arst_next got pc=%h cnt=%0d want 400/1", o_deq_pc, o_count); end
    drain_check("arst", 1);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_concurrent();
    test_wrap();
    test_empty_mask();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
